// File: rtl/sb_pkg.sv
// Shared widths, depth constants and the buffered-store record for the
// store buffer that sits between the core and the data memory.
package sb_pkg;

  localparam int SB_WIDTH    = 32;
  localparam int SB_AD_WIDTH = 32;
  localparam int SB_DEPTH    = 4;
  localparam int SB_PTR_W    = 2;

  // One pending store: whole-word address and data, no byte enables.
  typedef struct packed {
    logic [SB_AD_WIDTH-1:0] addr;
    logic [SB_WIDTH-1:0]    data;
  } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Store-to-load forwarding lookup: finds the youngest valid buffered store
// whose full address equals the lookup address. Purely combinational.
module sb_fwd_match
  import sb_pkg::*;
#(
  parameter int Width    = SB_WIDTH,
  parameter int AD_Width = SB_AD_WIDTH,
  parameter int Depth    = SB_DEPTH,
  parameter int PTR_W    = SB_PTR_W
) (
  input  logic [Depth-1:0]               valid_i,
  input  logic [Depth-1:0][AD_Width-1:0] addr_i,
  input  logic [Depth-1:0][Width-1:0]    data_i,
  input  logic [PTR_W-1:0]               head_i,
  input  logic [AD_Width-1:0]            lookup_addr_i,
  output logic                           hit_o,
  output logic [Width-1:0]               data_o
);

  // Walk entries from oldest (head) to youngest so a younger match overwrites an older one.
  always_comb begin
    logic [PTR_W-1:0] idx;
    // NOTE: every output gets a default before the loop; without it a
    // no-match path would leave hit_o/data_o unassigned and infer a latch.
    hit_o  = 1'b0;
    data_o = '0;
    idx    = head_i;
    for (int age = 0; age < Depth; age++) begin
      idx = head_i + PTR_W'(age);
      if (valid_i[idx] && (addr_i[idx] == lookup_addr_i)) begin
        hit_o  = 1'b1;
        data_o = data_i[idx];
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer in front of the data memory. Stores are accepted in one
// cycle, queued in a small circular FIFO and drained one per cycle whenever the
// core is not loading; loads that hit a pending store are forwarded the
// youngest matching data so the core sees memory as if every store completed.
module store_buffer
  import sb_pkg::*;
#(
  parameter int Width    = SB_WIDTH,
  parameter int AD_Width = SB_AD_WIDTH,
  parameter int Depth    = SB_DEPTH,
  parameter int PTR_W    = SB_PTR_W
) (
  input  logic                clk,
  input  logic                Res,
  input  logic                cpu_wr_en,
  input  logic                cpu_rd_en,
  input  logic [AD_Width-1:0] cpu_addr,
  input  logic [Width-1:0]    cpu_wdata,
  output logic [Width-1:0]    cpu_rdata,
  output logic                fwd_hit,
  output logic                stall,
  output logic                mem_wr_en,
  output logic [AD_Width-1:0] mem_addr,
  output logic [Width-1:0]    mem_wdata,
  input  logic [Width-1:0]    mem_rdata,
  output logic                empty,
  output logic [PTR_W:0]      count
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(Depth);

  // FIFO control state
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [Depth-1:0] valid_q, valid_d;

  // Entry storage
  logic [Depth-1:0][AD_Width-1:0] addr_q;
  logic [Depth-1:0][Width-1:0]    data_q;

  logic             full;
  logic             push;
  logic             pop;
  logic             match_hit;
  logic [Width-1:0] match_data;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_COUNT);

  // A store is refused while full even if a drain frees a slot this cycle.
  assign stall = cpu_wr_en & full;
  assign push  = cpu_wr_en & ~full;

  // Loads own the single memory port; draining is also held off during reset
  // so that pending stores are discarded without touching memory.
  assign pop = ~empty & ~cpu_rd_en & Res;

  // Next-state for pointers, occupancy and valid bits.
  always_comb begin
    // NOTE: combinational logic uses blocking '=' so later statements see the
    // updated value; state registers below use non-blocking '<=' only.
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    if (push) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!Res) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Capture an accepted store into the tail slot.
  always_ff @(posedge clk) begin
    // NOTE: entry storage is deliberately not reset; the valid bits alone
    // decide whether a slot means anything, which keeps this a plain RAM.
    if (push) begin
      addr_q[tail_q] <= cpu_addr;
      data_q[tail_q] <= cpu_wdata;
    end
  end

  sb_fwd_match #(
    .Width   (Width),
    .AD_Width(AD_Width),
    .Depth   (Depth),
    .PTR_W   (PTR_W)
  ) u_fwd_match (
    .valid_i      (valid_q),
    .addr_i       (addr_q),
    .data_i       (data_q),
    .head_i       (head_q),
    .lookup_addr_i(cpu_addr),
    .hit_o        (match_hit),
    .data_o       (match_data)
  );

  // Memory port: head entry while draining, otherwise the core address.
  assign mem_wr_en = pop;
  assign mem_addr  = pop ? addr_q[head_q] : cpu_addr;
  assign mem_wdata = data_q[head_q];

  // Load return path: forwarded data on a hit, memory data otherwise.
  assign fwd_hit   = cpu_rd_en & match_hit;
  assign cpu_rdata = fwd_hit ? match_data : mem_rdata;

  assign count = count_q;

endmodule
